// File: rtl/clk_enable_sequencer.sv
// PLL lock qualification, core reset release and clock-enable generation, all on clk.
//   state     | meaning
//   WAIT_LOCK | waiting for synchronized PLL lock
//   STABILIZE | counting consecutive locked cycles
//   RUN       | core out of reset, enables running
module clk_enable_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int CPU_FAST_DIV        = 4,
  parameter int CPU_SLOW_DIV        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       cpu_slow,
  output logic       sys_reset_n,
  output logic       ce_14m,
  output logic       ce_7m,
  output logic       ce_cpu,
  output logic [1:0] seq_state,
  output logic       lock_timeout,
  output logic [7:0] relock_count
);

  localparam int SW   = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int DMAX = (CPU_SLOW_DIV > CPU_FAST_DIV) ? CPU_SLOW_DIV : CPU_FAST_DIV;
  localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            locked_s;
  logic [SW-1:0]   stable_cnt, stable_nx;
  logic [TW-1:0]   timeout_cnt;
  logic [2:0]      phase;
  logic [CW-1:0]   cpu_cnt;
  logic [CW-1:0]   div_m1;
  logic            div_slow;
  logic            run_nx;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign seq_state = state;
  assign run_nx    = (state_nx == RUN);
  assign div_m1    = div_slow ? CW'(CPU_SLOW_DIV - 1) : CW'(CPU_FAST_DIV - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      state  <= WAIT_LOCK;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state  <= state_nx;
    end
  end

  // A lock drop is checked before the threshold, so it wins on the same cycle.
  always_comb begin
    state_nx  = state;
    stable_nx = stable_cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nx  = STABILIZE;
          stable_nx = SW'(1);
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_nx  = WAIT_LOCK;
          stable_nx = '0;
        end else if (stable_cnt == SW'(LOCK_STABLE_CYCLES)) begin
          state_nx  = RUN;
          stable_nx = '0;
        end else begin
          stable_nx = stable_cnt + SW'(1);
        end
      end
      RUN: begin
        stable_nx = '0;
        if (!locked_s) state_nx = WAIT_LOCK;
      end
      default: begin
        state_nx  = WAIT_LOCK;
        stable_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_cnt   <= '0;
      sys_reset_n  <= 1'b0;
      phase        <= '0;
      cpu_cnt      <= '0;
      div_slow     <= 1'b0;
      ce_14m       <= 1'b0;
      ce_7m        <= 1'b0;
      ce_cpu       <= 1'b0;
      timeout_cnt  <= '0;
      lock_timeout <= 1'b0;
      relock_count <= '0;
    end else begin
      stable_cnt  <= stable_nx;
      sys_reset_n <= run_nx;

      if (!run_nx) begin
        phase   <= '0;
        cpu_cnt <= '0;
        ce_14m  <= 1'b0;
        ce_7m   <= 1'b0;
        ce_cpu  <= 1'b0;
      end else if (state != RUN) begin
        phase    <= '0;
        cpu_cnt  <= '0;
        ce_14m   <= 1'b0;
        ce_7m    <= 1'b0;
        ce_cpu   <= 1'b0;
        div_slow <= cpu_slow;
      end else begin
        // Enables are registered one cycle ahead of the phase they mark.
        phase  <= phase + 3'd1;
        ce_14m <= (phase[1:0] == 2'd2);
        ce_7m  <= (phase == 3'd6);
        ce_cpu <= 1'b0;
        if (phase == 3'd6) begin
          if (cpu_cnt == div_m1) begin
            cpu_cnt <= '0;
            ce_cpu  <= 1'b1;
          end else begin
            cpu_cnt <= cpu_cnt + CW'(1);
          end
        end
        if (ce_cpu) div_slow <= cpu_slow;
      end

      if (state == RUN && !run_nx && relock_count != 8'hff)
        relock_count <= relock_count + 8'd1;

      if (run_nx) begin
        timeout_cnt  <= '0;
        lock_timeout <= 1'b0;
      end else if (state != RUN) begin
        if (timeout_cnt == TW'(LOCK_TIMEOUT_CYCLES)) lock_timeout <= 1'b1;
        else timeout_cnt <= timeout_cnt + TW'(1);
      end
    end
  end

endmodule

// File: doc/clk_enable_sequencer.md
Name: clk_enable_sequencer

Overview:
- Consumes the PLL lock indication and its 57.272728 MHz output clock.
- Produces the system reset and the 14.318182 MHz, 7.159091 MHz and CPU (1.79/1.19 MHz) clock enables used by the core.
- Sits directly downstream of the PLL wrapper. All core logic runs on clk with these enables, never on derived clocks.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release
LOCK_TIMEOUT_CYCLES, 1048576, cycles outside RUN before lock_timeout is flagged
CPU_FAST_DIV, 4, ce_7m pulses per ce_cpu in fast mode
CPU_SLOW_DIV, 6, ce_7m pulses per ce_cpu in slow mode

Ports:
clk  in  1  57.272728 MHz PLL output clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
pll_locked  in  1  PLL locked, asynchronous to clk
cpu_slow  in  1  1 = slow CPU divide (TIA/RIOT access), 0 = fast
sys_reset_n  out  1  core reset, active-low; high only in RUN
ce_14m  out  1  one-cycle enable, every 4 clk cycles
ce_7m  out  1  one-cycle enable, every 8 clk cycles
ce_cpu  out  1  one-cycle enable, every 8*DIV clk cycles
seq_state  out  2  0=WAIT_LOCK, 1=STABILIZE, 2=RUN
lock_timeout  out  1  timeout flag
relock_count  out  8  count of lock losses while in RUN, saturating at 255

Behaviour:
- Reset: rst_n is sampled low on a clk edge, giving on the next cycle:
  - state=WAIT_LOCK, all counters and sync flops 0
  - sys_reset_n=0, ce_*=0, lock_timeout=0, relock_count=0
- Synchronizer: locked_s = pll_locked delayed by SYNC_STAGES flops. The FSM uses only locked_s.
- WAIT_LOCK:
  - locked_s=1 -> STABILIZE with stable_cnt=1.
  - Otherwise stay.
- STABILIZE:
  - locked_s=0 -> WAIT_LOCK, stable_cnt=0.
  - Else stable_cnt++. When stable_cnt reaches LOCK_STABLE_CYCLES -> RUN.
- RUN:
  - sys_reset_n=1 starting the first cycle seq_state==2. It is registered, same cycle as the state change.
  - locked_s=0 -> WAIT_LOCK; sys_reset_n=0 on that same next cycle; relock_count++ (saturates at 255, no wrap).
- Timeout counter:
  - Counts every cycle the FSM is not in RUN; cleared on entering RUN.
  - On reaching LOCK_TIMEOUT_CYCLES, lock_timeout=1 and the counter holds.
  - lock_timeout clears on entry to RUN. The FSM is otherwise unaffected.
- Enable generation (only in RUN; outside RUN all ce_*=0 and the phase counters are held at 0):
  - phase: 3-bit counter starting at 0 on the first RUN cycle, +1 per cycle, wraps at 7.
  - ce_14m=1 when phase[1:0]==3; ce_7m=1 when phase==7. ce_7m always coincides with a ce_14m.
  - cpu_cnt increments on each ce_7m. ce_cpu=1 on the ce_7m at which cpu_cnt==div-1; cpu_cnt then returns to 0.
  - div is latched from cpu_slow (CPU_SLOW_DIV if 1, else CPU_FAST_DIV):
    - at RUN entry;
    - on every ce_cpu cycle, for the next period.
  - A cpu_slow change mid-period never shortens or stretches the current period.
  - First enables after RUN entry (RUN entry = cycle 0):
    - ce_14m at cycles 3, 7, 11, ...
    - ce_7m at cycles 7, 15, ...
    - ce_cpu at cycle 31 (fast) or 47 (slow).
- Lock loss in RUN: enables stop the cycle sys_reset_n falls. No partial CPU period completes.
- Simultaneous events:
  - A locked_s drop in the same cycle stable_cnt would reach the threshold -> WAIT_LOCK wins.
  - rst_n low overrides everything.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
(Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=64.)
- Power-up: hold rst_n=0 for 5 cycles, then pll_locked=1 -> seq_state goes 0->1 two cycles after locked, RUN 16 cycles later, sys_reset_n=1 in that same cycle; all outputs 0 during reset.
- Glitch rejection: locked high for 10 cycles, low for 1, high again -> returns to WAIT_LOCK, stable count restarts, RUN reached 16 cycles after the second rise.
- Enable cadence, cpu_slow=0: over 256 RUN cycles -> 64 ce_14m, 32 ce_7m, 8 ce_cpu; first at cycles 3/7/31; ce_cpu always coincident with ce_7m.
- Divider switch: toggle cpu_slow to 1 at cycle 40 of RUN -> ce_cpu at 31, 63 (period already running keeps 32), then 111, 159 (48-cycle spacing).
- Lock loss: drop pll_locked in RUN -> two cycles later seq_state=0, sys_reset_n=0, all ce_*=0, relock_count=1; repeat 300 times -> saturates at 255.
- Timeout: keep pll_locked=0 after reset -> lock_timeout=1 exactly 64 cycles after reset release; then lock -> flag clears at RUN entry.
